// File: rtl/scan_led_driver.sv
// Time-multiplexed seven-segment driver: one digit per slot with leading blanking,
// double-buffered digit bank that only swaps at frame boundaries.
module scan_led_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 4,
  parameter int ADDR_W       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [4:0]            wr_data,
  input  logic                  commit,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_sync,
  output logic                  update_done
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0] LAST_DIG  = DIG_W'(NUM_DIGITS - 1);

  typedef enum logic {S_BLANK, S_DRIVE} slot_state_e;

  slot_state_e      state, state_d;
  logic [CNT_W-1:0] slot_cnt, cnt_d;
  logic [DIG_W-1:0] digit, digit_d;
  logic             pending;
  logic [4:0]       shadow [NUM_DIGITS];
  logic [4:0]       active [NUM_DIGITS];

  logic                  boundary, load;
  logic [4:0]            cur;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    unique case (v)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      4'hF: glyph = 7'b0111000;
    endcase
  endfunction

  assign boundary = (slot_cnt == LAST_CNT) && (digit == LAST_DIG);
  // A commit arriving in the boundary cycle itself is honoured immediately.
  assign load     = boundary && (pending || commit);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt_d   = slot_cnt + 1'b1;
    digit_d = digit;
    if (slot_cnt == LAST_CNT) begin
      cnt_d   = '0;
      digit_d = (digit == LAST_DIG) ? '0 : digit + 1'b1;
    end
    state_d = (cnt_d < BLANK_END) ? S_BLANK : S_DRIVE;

    cur   = '0;
    an_d  = '1;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit == DIG_W'(i)) cur = active[i];
    end
    if (state == S_DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = (digit != DIG_W'(i));
      seg_d = glyph(cur[3:0]);
      dp_d  = ~cur[4];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
      digit    <= '0;
      state    <= S_BLANK;
      pending  <= 1'b0;
    end else begin
      slot_cnt <= cnt_d;
      digit    <= digit_d;
      state    <= state_d;
      pending  <= boundary ? 1'b0 : (pending | commit);
    end
  end

  // NOTE: the digit banks are small register arrays and must read as zero after reset, so they are reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      // The copy samples pre-edge shadow, so a same-cycle write lands in shadow only.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (load) active[i] <= shadow[i];
        if (wr_en && (wr_addr == ADDR_W'(i))) shadow[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an          <= '1;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      frame_sync  <= 1'b0;
      update_done <= 1'b0;
    end else begin
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
      frame_sync  <= (slot_cnt == '0) && (digit == '0);
      update_done <= load;
    end
  end

endmodule

// File: tb/tb_scan_led_driver.sv
// Scoreboard bench: two instances (4 and 3 digits) share stimulus; a frame-arithmetic
// model predicts each cycle's outputs and a monitor compares them as they appear.
module tb_scan_led_driver;

  localparam int S = 8;
  localparam int B = 2;
  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
    logic       ud;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       commit = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [4:0] wr_data = '0;

  logic [3:0] an4;
  logic [2:0] an3;
  logic [6:0] seg4, seg3;
  logic       dp4, dp3, fs4, fs3, ud4, ud3;

  scan_led_driver #(.NUM_DIGITS(4), .SLOT_CYCLES(S), .BLANK_CYCLES(B), .ADDR_W(2)) dut4 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .an(an4), .seg(seg4), .dp(dp4), .frame_sync(fs4), .update_done(ud4));

  scan_led_driver #(.NUM_DIGITS(3), .SLOT_CYCLES(S), .BLANK_CYCLES(B), .ADDR_W(2)) dut3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .an(an3), .seg(seg3), .dp(dp3), .frame_sync(fs3), .update_done(ud3));

  always #5 clk = ~clk;

  exp_t       q4[$], q3[$];
  logic [4:0] m_shadow [2][8];
  logic [4:0] m_active [2][8];
  bit         m_pending [2];
  int         m_k [2];
  int         checks = 0;
  int         passed = 0;

  task automatic check(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s @%0t: got an=%b seg=%b dp=%b fs=%b ud=%b, expected an=%b seg=%b dp=%b fs=%b ud=%b",
                  name, $time, act.an, act.seg, act.dp, act.fs, act.ud,
                  exp.an, exp.seg, exp.dp, exp.fs, exp.ud);
  endtask

  // Expected outputs for the cycle after the current one, then advance the model one clock.
  task automatic model_step(input int j, output exp_t e);
    int n, p, d;
    bit bnd, ld;
    logic [7:0] ones;
    n    = (j == 0) ? 4 : 3;
    ones = 8'((1 << n) - 1);
    e = '{an: ones, seg: 7'b1111111, dp: 1'b1, fs: 1'b0, ud: 1'b0};
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_shadow[j][i] = '0;
        m_active[j][i] = '0;
      end
      m_pending[j] = 0;
      m_k[j] = 0;
      return;
    end
    p = m_k[j] % S;
    d = (m_k[j] / S) % n;
    if (p >= B) begin
      e.an  = ones & ~(8'd1 << d);
      e.seg = GLYPH[m_active[j][d][3:0]];
      e.dp  = ~m_active[j][d][4];
    end
    e.fs = (p == 0) && (d == 0);
    bnd  = (p == S - 1) && (d == n - 1);
    ld   = bnd && (m_pending[j] || commit);
    e.ud = ld;
    if (ld) for (int i = 0; i < n; i++) m_active[j][i] = m_shadow[j][i];
    if (wr_en && (int'(wr_addr) < n)) m_shadow[j][wr_addr] = wr_data;
    m_pending[j] = bnd ? 0 : (m_pending[j] | commit);
    m_k[j]++;
  endtask

  task automatic step(input bit r, input bit we, input logic [1:0] a, input logic [4:0] dat, input bit cm);
    exp_t e;
    @(negedge clk);
    reset = r; wr_en = we; wr_addr = a; wr_data = dat; commit = cm;
    model_step(0, e); q4.push_back(e);
    model_step(1, e); q3.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'd0, 5'd0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      a = '{an: 8'(an4), seg: seg4, dp: dp4, fs: fs4, ud: ud4};
      check("dut4_out", a, e);
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      a = '{an: 8'(an3), seg: seg3, dp: dp3, fs: fs3, ud: ud3};
      check("dut3_out", a, e);
    end
  end

  initial begin
    exp_t blank4, blank3, a;
    blank4 = '{an: 8'h0F, seg: 7'b1111111, dp: 1'b1, fs: 1'b0, ud: 1'b0};
    blank3 = '{an: 8'h07, seg: 7'b1111111, dp: 1'b1, fs: 1'b0, ud: 1'b0};

    for (int i = 0; i < 3; i++) step(1, 0, 2'd0, 5'd0, 0);
    idle(40);

    // Stage new values, commit mid-frame, watch the swap at the boundary.
    step(0, 1, 2'd0, 5'h14, 0);
    step(0, 1, 2'd3, 5'h0F, 0);
    idle(5);
    step(0, 0, 2'd0, 5'd0, 1);
    idle(64);

    // Uncommitted write stays invisible for several frames.
    step(0, 1, 2'd1, 5'h08, 0);
    idle(96);
    step(0, 0, 2'd0, 5'd0, 1);
    idle(40);

    // Write plus commit exactly in the 4-digit boundary cycle.
    while (m_k[0] % (4 * S) != 4 * S - 1) idle(1);
    step(0, 1, 2'd2, 5'h05, 1);
    idle(40);
    step(0, 0, 2'd0, 5'd0, 1);
    idle(40);

    // Address 3 is valid for four digits and out of range for three.
    step(0, 1, 2'd3, 5'h1A, 1);
    idle(40);

    for (int i = 0; i < 600; i++)
      step(0, ($urandom % 4) == 0, 2'($urandom), 5'($urandom), ($urandom % 20) == 0);

    // Asynchronous reset while digit 2 is driven and a commit is pending.
    step(0, 1, 2'd2, 5'h1E, 0);
    step(0, 0, 2'd0, 5'd0, 1);
    while (m_k[0] % (4 * S) != 2 * S + 4) idle(1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    a = '{an: 8'(an4), seg: seg4, dp: dp4, fs: fs4, ud: ud4};
    check("async_reset_dut4", a, blank4);
    a = '{an: 8'(an3), seg: seg3, dp: dp3, fs: fs3, ud: ud3};
    check("async_reset_dut3", a, blank3);
    for (int i = 0; i < 3; i++) step(1, 0, 2'd0, 5'd0, 0);
    idle(80);

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
